// File: rtl/fcmp_sched.sv
// fcmp_sched: shares one FPU compare unit (feq/flt/fle) between two requesters.
// Requester 0 is the FPU ALU issue port and requester 1 is the branch unit.
// A round-robin arbiter issues at most one operation per cycle. A tag pipe
// follows each operation through the unit's fixed latency, and each result is
// returned through a per-requester response FIFO. Credits cover both queued and
// in-flight results, so a FIFO can never overflow.
// Optional feature: define FCMP_SANITIZE_EN to replace NaN operands with +inf and
// denormal operands with +0 before they are registered onto cmp_x1/cmp_x2.
module fcmp_sched #(
    parameter int CMP_LAT    = 1,   // compare-unit latency, 0..4
    parameter int RESP_DEPTH = 2    // entries per response FIFO, power of two
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_x1,
    input  logic [63:0] req_x2,
    output logic        cmp_valid,
    output logic [1:0]  cmp_op,
    output logic [31:0] cmp_x1,
    output logic [31:0] cmp_x2,
    input  logic        cmp_y,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [1:0]  resp_y
);

    localparam int STAGES = CMP_LAT + 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    // Wide enough for fifo count plus in-flight count without wrapping.
    localparam int CNT_W  = $clog2(RESP_DEPTH + STAGES + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } cmp_op_e;

    // Operand conditioning applied on the way into the issue register.
    function automatic logic [31:0] sanitize(input logic [31:0] v);
`ifdef FCMP_SANITIZE_EN
        if (v[30:23] == 8'hff && v[22:0] != 23'd0) begin
            return 32'h7f80_0000;
        end else if (v[30:23] == 8'h00 && v[22:0] != 23'd0) begin
            return 32'h0000_0000;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // ---------------------------------------------------------------- state
    logic              last_q, last_d;            // id granted most recently
    logic              cmp_valid_q, cmp_valid_d;
    logic [1:0]        cmp_op_q, cmp_op_d;
    logic [31:0]       cmp_x1_q, cmp_x1_d;
    logic [31:0]       cmp_x2_q, cmp_x2_d;
    logic [STAGES-1:0] tag_v_q, tag_v_d;
    logic [STAGES-1:0] tag_id_q, tag_id_d;
    cnt_t              fifo_cnt_q [2];
    cnt_t              fifo_cnt_d [2];
    ptr_t              wr_ptr_q [2];
    ptr_t              wr_ptr_d [2];
    ptr_t              rd_ptr_q [2];
    ptr_t              rd_ptr_d [2];
    logic              mem_q [2][RESP_DEPTH];

    // ---------------------------------------------------------------- nets
    cnt_t        inflight [2];
    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic [1:0]  push;
    logic [1:0]  pop;
    cmp_op_e     sel_op;
    logic [31:0] sel_x1;
    logic [31:0] sel_x2;
    logic        ret_v;
    logic        ret_id;

    assign sel_op = cmp_op_e'(grant[1] ? req_op[3:2] : req_op[1:0]);
    assign sel_x1 = grant[1] ? req_x1[63:32] : req_x1[31:0];
    assign sel_x2 = grant[1] ? req_x2[63:32] : req_x2[31:0];
    assign ret_v  = tag_v_q[STAGES-1];
    assign ret_id = tag_id_q[STAGES-1];

    // Credit check: a requester may issue only while queued plus in-flight results leave room.
    always_comb begin
        eligible = 2'b00;
        for (int i = 0; i < 2; i++) begin
            inflight[i] = '0;
            for (int s = 0; s < STAGES; s++) begin
                if (tag_v_q[s] && (tag_id_q[s] == 1'(i))) begin
                    inflight[i] = inflight[i] + cnt_t'(1);
                end
            end
            eligible[i] = req_valid[i] && ((fifo_cnt_q[i] + inflight[i]) < cnt_t'(RESP_DEPTH));
        end
    end

    // Round-robin grant: on a tie, favour the requester not granted most recently.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves it unassigned would infer a latch.
        grant = 2'b00;
        if (rstn) begin
            if (eligible == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    assign req_ready = grant;

    // Issue register and tag pipe: load on a grant, otherwise drop valid and hold operands.
    always_comb begin
        cmp_valid_d = 1'b0;
        cmp_op_d    = cmp_op_q;
        cmp_x1_d    = cmp_x1_q;
        cmp_x2_d    = cmp_x2_q;
        last_d      = last_q;
        if (grant != 2'b00) begin
            cmp_valid_d = 1'b1;
            cmp_op_d    = (sel_op == OP_RSV) ? OP_FEQ : sel_op;
            cmp_x1_d    = sanitize(sel_x1);
            cmp_x2_d    = sanitize(sel_x2);
            last_d      = grant[1];
        end
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        tag_v_d[0]  = (grant != 2'b00);
        tag_id_d[0] = grant[1];
        for (int s = 1; s < STAGES; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
    end

    // Response FIFO control: push from the last tag stage, pop on resp_ready when non-empty.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            push[i]       = ret_v && (ret_id == 1'(i));
            pop[i]        = resp_ready[i] && (fifo_cnt_q[i] != '0);
            fifo_cnt_d[i] = fifo_cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
            wr_ptr_d[i]   = wr_ptr_q[i];
            rd_ptr_d[i]   = rd_ptr_q[i];
            if (push[i]) begin
                wr_ptr_d[i] = (wr_ptr_q[i] == ptr_t'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q[i] + ptr_t'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = (rd_ptr_q[i] == ptr_t'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q[i] + ptr_t'(1);
            end
        end
    end

    // Head of each FIFO, forced to zero while the FIFO is empty.
    always_comb begin
        resp_valid = 2'b00;
        resp_y     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            resp_valid[i] = (fifo_cnt_q[i] != '0);
            resp_y[i]     = resp_valid[i] & mem_q[i][rd_ptr_q[i]];
        end
    end

    // Control state register; reset discards every in-flight and queued result.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state is assigned with <= so all flops update from
        // pre-edge values, independent of statement order.
        if (!rstn) begin
            last_q      <= 1'b1;
            cmp_valid_q <= 1'b0;
            cmp_op_q    <= 2'b00;
            cmp_x1_q    <= '0;
            cmp_x2_q    <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_cnt_q[i] <= '0;
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
            end
        end else begin
            last_q      <= last_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_op_q    <= cmp_op_d;
            cmp_x1_q    <= cmp_x1_d;
            cmp_x2_q    <= cmp_x2_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            for (int i = 0; i < 2; i++) begin
                fifo_cnt_q[i] <= fifo_cnt_d[i];
                wr_ptr_q[i]   <= wr_ptr_d[i];
                rd_ptr_q[i]   <= rd_ptr_d[i];
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; counts and pointers are, and resp_y is
        // gated by non-empty, so stale entries are never observed.
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= cmp_y;
            end
        end
    end

    assign cmp_valid = cmp_valid_q;
    assign cmp_op    = cmp_op_q;
    assign cmp_x1    = cmp_x1_q;
    assign cmp_x2    = cmp_x2_q;

endmodule
